decodificador_bdc: RTL and testbench

- Sequential inverse of the binary-to-7-segment BCD converter: takes the pattern shown on NUM_DIGITS seven-segment displays and recovers the binary value.
- Flags any pattern that is not a legal decimal glyph.
- Sits on the readback/self-check path of the display subsystem, e.g. to verify display drivers on the board.
- Conversion is multi-cycle: one digit per clock, with a start/busy/done handshake.

---
 rtl/decodificador_bdc_pkg.sv | 28 ++
 rtl/seg7_a_bcd.sv | 38 +++
 rtl/decodificador_bdc.sv | 120 ++++++++++++
 tb/tb_decodificador_bdc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decodificador_bdc_pkg.sv
// Shared types and seven-segment glyph constants (active-low abcdefg, a is MSB)
// for the segment-to-binary readback decoder.
package decodificador_bdc_pkg;

  localparam int SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  // Tail-less 6 and 9 as produced by some display drivers
  localparam logic [SEG_W-1:0] SEG_6_ALT = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_9_ALT = 7'b0001100;

endpackage

// File: rtl/seg7_a_bcd.sv
// Combinational single-digit decoder: active-low segment pattern to BCD digit,
// with legal-glyph and blank indications.
module seg7_a_bcd
  import decodificador_bdc_pkg::*;
(
  input  logic [SEG_W-1:0] i_pattern,
  output logic [3:0]       o_digit,
  output logic             o_valid,
  output logic             o_blank
);

  // Glyph lookup; a blank is reported separately and is not a valid digit
  always_comb begin
    o_digit = 4'd0;
    o_valid = 1'b1;
    o_blank = 1'b0;
    case (i_pattern)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_6_ALT: o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_9_ALT: o_digit = 4'd9;
      SEG_BLANK: begin
        o_valid = 1'b0;
        o_blank = 1'b1;
      end
      default:   o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/decodificador_bdc.sv
// Multi-cycle seven-segment to binary decoder, one digit per clock, MSD first.
// Define DECODIFICADOR_SEG_ACTIVE_HIGH_EN for active-high display inputs.
module decodificador_bdc
  import decodificador_bdc_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_W      = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SEG_W*NUM_DIGITS-1:0] display,
  output logic                        busy,
  output logic                        done,
  output logic [BIN_W-1:0]            binary,
  output logic                        err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                      r_state;
  logic [SEG_W*NUM_DIGITS-1:0] r_shadow;
  logic [IDX_W-1:0]            r_idx;
  logic [BIN_W-1:0]            r_acc;
  logic                        r_seen;
  logic                        r_error;
  logic                        r_busy;
  logic                        r_done;
  logic [BIN_W-1:0]            r_binary;
  logic                        r_err;

  logic [SEG_W-1:0]            w_pattern_raw;
  logic [SEG_W-1:0]            w_pattern;
  logic [3:0]                  w_digit;
  logic                        w_valid;
  logic                        w_blank;
  logic [BIN_W-1:0]            w_acc_next;

  assign w_pattern_raw = r_shadow[r_idx*SEG_W +: SEG_W];

`ifdef DECODIFICADOR_SEG_ACTIVE_HIGH_EN
  assign w_pattern = ~w_pattern_raw;
`else
  assign w_pattern = w_pattern_raw;
`endif

  seg7_a_bcd u_seg7_a_bcd (
    .i_pattern (w_pattern),
    .o_digit   (w_digit),
    .o_valid   (w_valid),
    .o_blank   (w_blank)
  );

  // acc*10 + digit built from shifts; a blank decodes as digit 0
  assign w_acc_next = (r_acc << 2'd3) + (r_acc << 1'd1) + BIN_W'(w_digit);

  // Handshake FSM, digit accumulation and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_seen   <= 1'b0;
      r_error  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_binary <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shadow <= display;
            r_acc    <= '0;
            r_seen   <= 1'b0;
            r_error  <= 1'b0;
            r_idx    <= LAST_IDX;
            r_busy   <= 1'b1;
            r_state  <= DECODE;
          end
        end
        DECODE: begin
          if (w_valid) begin
            r_acc  <= w_acc_next;
            r_seen <= 1'b1;
          end else if (w_blank && !r_seen) begin
            r_acc  <= w_acc_next;
          end else begin
            r_error <= 1'b1;
          end
          if (r_idx == '0) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        DONE: begin
          r_binary <= r_error ? '0 : r_acc;
          r_err    <= r_error;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign binary = r_binary;
  assign err    = r_err;

endmodule

// File: tb/tb_decodificador_bdc.sv
// Self-checking bench for decodificador_bdc: cycle-level reference model plus
// directed conversions with hand-computed results.
module tb_decodificador_bdc;

  localparam int ND = 2;
  localparam int BW = 7;

  localparam logic [6:0] G_BL = 7'b1111111;
  localparam logic [6:0] G_0  = 7'b0000001;
  localparam logic [6:0] G_1  = 7'b1001111;
  localparam logic [6:0] G_2  = 7'b0010010;
  localparam logic [6:0] G_3  = 7'b0000110;
  localparam logic [6:0] G_4  = 7'b1001100;
  localparam logic [6:0] G_5  = 7'b0100100;
  localparam logic [6:0] G_6  = 7'b0100000;
  localparam logic [6:0] G_7  = 7'b0001111;
  localparam logic [6:0] G_9  = 7'b0000100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [13:0]   disp_al;
  logic [13:0]   display;
  logic          busy;
  logic          done;
  logic [BW-1:0] binary;
  logic          err;

  always #5 clk = ~clk;

`ifdef DECODIFICADOR_SEG_ACTIVE_HIGH_EN
  assign display = ~disp_al;
`else
  assign display = disp_al;
`endif

  decodificador_bdc #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .display (display),
    .busy    (busy),
    .done    (done),
    .binary  (binary),
    .err     (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Glyph value: 0..9, -1 for blank, -2 for anything else
  function automatic int glyph(input logic [6:0] p);
    case (p)
      7'b0000001: return 0;
      7'b1001111: return 1;
      7'b0010010: return 2;
      7'b0000110: return 3;
      7'b1001100: return 4;
      7'b0100100: return 5;
      7'b0100000: return 6;
      7'b1100000: return 6;
      7'b0001111: return 7;
      7'b0000000: return 8;
      7'b0000100: return 9;
      7'b0001100: return 9;
      7'b1111111: return -1;
      default:    return -2;
    endcase
  endfunction

  task automatic model_decode(input logic [13:0] d, output int v, output bit e);
    bit seen;
    int g;
    seen = 1'b0;
    v = 0;
    e = 1'b0;
    for (int i = ND - 1; i >= 0; i--) begin
      g = glyph(d[i*7 +: 7]);
      if (g >= 0) begin
        v = v * 10 + g;
        seen = 1'b1;
      end else if (g == -1 && !seen) begin
        v = v * 10;
      end else begin
        e = 1'b1;
      end
    end
    v = e ? 0 : v % (1 << BW);
  endtask

  // Reference: phase counts edges since an accepted start
  int m_phase = 0;
  bit m_valid = 1'b0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;
  int m_bin   = 0;
  int c_bin   = 0;
  bit c_err   = 1'b0;

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (!rst) begin
      m_phase = 0;
      m_done  = 1'b0;
      m_bin   = 0;
      m_err   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          model_decode(disp_al, c_bin, c_err);
          m_phase = 1;
        end
      end else if (m_phase == ND + 1) begin
        m_done  = 1'b1;
        m_bin   = c_bin;
        m_err   = c_err;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, (m_phase != 0));
      chk("done", done, m_done);
      chk("binary", binary, m_bin);
      chk("err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic convert(input logic [13:0] pat, input int eb, input bit ee, input string nm);
    int lat;
    disp_al = pat;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_bin"}, binary, eb);
    chk({nm, "_err"}, err, ee);
    tick();
  endtask

  initial begin
    int seen_done;
    rst = 1'b0;
    start = 1'b0;
    disp_al = {G_BL, G_BL};
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", binary, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    tick();

    convert({G_BL, G_7}, 7, 1'b0, "seven");
    convert({G_1, G_2}, 12, 1'b0, "twelve");
    convert({G_9, G_9}, 99, 1'b0, "ninety_nine");
    convert({G_0, G_0}, 0, 1'b0, "zeros");
    convert({G_BL, G_BL}, 0, 1'b0, "all_blank");
    convert({G_1, G_BL}, 0, 1'b1, "trailing_blank");
    convert({G_0, 7'b0110110}, 0, 1'b1, "bad_units");
    convert({G_BL, G_3}, 3, 1'b0, "err_clear");
    convert({7'b1100000, 7'b0001100}, 69, 1'b0, "alt_glyphs");

    // Display change and re-start while decoding are ignored
    disp_al = {G_4, G_5};
    start = 1'b1;
    tick();
    disp_al = {G_2, G_2};
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("capture_done", done, 1);
    chk("capture_bin", binary, 45);
    tick();

    // Start while in DONE is not queued
    disp_al = {G_6, G_1};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_state_done", done, 1);
    chk("done_state_bin", binary, 61);
    tick();
    chk("done_state_ignored", busy, 0);
    tick();

    // Reset during DECODE aborts the conversion
    disp_al = {G_3, G_3};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_bin", binary, 0);
    chk("abort_done", done, 0);
    rst = 1'b1;
    seen_done = 0;
    repeat (5) begin
      tick();
      if (done === 1'b1) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);
    convert({G_2, G_5}, 25, 1'b0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
